// File: rtl/em604_multiplicador.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : em604_multiplicador                                        |
// | Description : Sequential shift-and-add multiplier, companion of the      |
// |               EM604 restoring divider. Shares its load/start/done        |
// |               handshake so one controller can drive both blocks.         |
// |               One SOMA/DESLOCA cycle pair per multiplier bit gives a     |
// |               2*WIDTH-bit product.                                       |
// | Parameters  : WIDTH     operand width (product is 2*WIDTH bits)          |
// | Ports       : clk       rising-edge clock                                |
// |               rst       asynchronous active-high reset                   |
// |               A, B      multiplicand / multiplier operands               |
// |               loadA/B   latch A/B (only when idle: INICIO or FIM)        |
// |               ini_mult  start request, level-sampled                     |
// |               P         product / working accumulator                    |
// |               fim_mult  done, high while in FIM                          |
// |               busy      high in SOMA, DESLOCA, CORRIGE                   |
// | Options     : EM604_MULT_SIGNED_EN  two's-complement operands; adds a    |
// |               CORRIGE cycle that negates the product when needed.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module em604_multiplicador #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 loadA,
   input  logic                 loadB,
   input  logic                 ini_mult,
   output logic [2*WIDTH-1:0]   P,
   output logic                 fim_mult,
   output logic                 busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last    = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_cnt_one = CW'(1);

   typedef enum logic [2:0] {
      INICIO  = 3'd0,
      SOMA    = 3'd1,
      DESLOCA = 3'd2,
      FIM     = 3'd3,
      CORRIGE = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_reg_a;
   logic [WIDTH-1:0]     r_reg_b;
   logic [2*WIDTH-1:0]   r_p;
   logic                 r_carry;
   logic [CW-1:0]        r_count;
   logic                 w_idle;
   logic [WIDTH-1:0]     w_b_op;
   logic [WIDTH-1:0]     w_mcand;
   logic [WIDTH-1:0]     w_mplier;
   logic [WIDTH:0]       w_sum;

   assign w_idle = (r_state == INICIO) || (r_state == FIM);
   // Multiplier operand bypasses from B when loaded on the start edge itself.
   assign w_b_op = loadB ? B : r_reg_b;

`ifdef EM604_MULT_SIGNED_EN
   localparam logic [WIDTH-1:0]   c_one_w = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] c_one_p = (2*WIDTH)'(1);
   logic                 r_neg;
   logic [WIDTH-1:0]     w_a_op;

   assign w_a_op   = loadA ? A : r_reg_a;
   // Magnitudes as W-bit unsigned; the most negative value maps onto 2^(W-1).
   assign w_mplier = w_b_op[WIDTH-1]  ? (~w_b_op + c_one_w)  : w_b_op;
   assign w_mcand  = r_reg_a[WIDTH-1] ? (~r_reg_a + c_one_w) : r_reg_a;
`else
   assign w_mplier = w_b_op;
   assign w_mcand  = r_reg_a;
`endif

   // W+1-bit add of the upper half; the extra bit becomes the shift-in carry.
   assign w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_mcand};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= INICIO;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and status decode
   always_comb begin
      w_next   = r_state;
      fim_mult = 1'b0;
      busy     = 1'b0;
      case (r_state)
         INICIO: begin
            if (ini_mult) w_next = SOMA;
         end
         SOMA: begin
            busy   = 1'b1;
            w_next = DESLOCA;
         end
         DESLOCA: begin
            busy = 1'b1;
            if (r_count == c_last) begin
`ifdef EM604_MULT_SIGNED_EN
               w_next = CORRIGE;
`else
               w_next = FIM;
`endif
            end else begin
               w_next = SOMA;
            end
         end
         FIM: begin
            fim_mult = 1'b1;
            if (ini_mult) w_next = SOMA;
         end
         CORRIGE: begin
            busy   = 1'b1;
            w_next = FIM;
         end
         default: w_next = INICIO;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reg_a <= '0;
         r_reg_b <= '0;
         r_p     <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
`ifdef EM604_MULT_SIGNED_EN
         r_neg   <= 1'b0;
`endif
      end else begin
         // Operand loads are only honoured while idle.
         if (w_idle) begin
            if (loadA) r_reg_a <= A;
            if (loadB) r_reg_b <= B;
         end
         case (r_state)
            INICIO, FIM: begin
               if (ini_mult) begin
                  r_p     <= {{WIDTH{1'b0}}, w_mplier};
                  r_count <= '0;
                  r_carry <= 1'b0;
`ifdef EM604_MULT_SIGNED_EN
                  r_neg   <= w_a_op[WIDTH-1] ^ w_b_op[WIDTH-1];
`endif
               end
            end
            SOMA: begin
               if (r_p[0]) begin
                  {r_carry, r_p[2*WIDTH-1:WIDTH]} <= w_sum;
               end else begin
                  r_carry <= 1'b0;
               end
            end
            DESLOCA: begin
               r_p     <= {r_carry, r_p[2*WIDTH-1:1]};
               r_count <= r_count + c_cnt_one;
            end
            CORRIGE: begin
`ifdef EM604_MULT_SIGNED_EN
               if (r_neg) r_p <= ~r_p + c_one_p;
`endif
            end
            default: ;
         endcase
      end
   end

   assign P = r_p;

endmodule
`default_nettype wire

// File: tb/tb_em604_multiplicador.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_em604_multiplicador                                     |
// | Description : Self-checking bench for em604_multiplicador (unsigned      |
// |               build): vector table plus reset / mid-run corner cases.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_em604_multiplicador;

   localparam int W   = 8;
   localparam int LAT = 2 * W;
   localparam logic [W-1:0] c_ga = 8'h5A;  // filler driven on A when not loading
   localparam logic [W-1:0] c_gb = 8'hC3;  // filler driven on B when not loading

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [W-1:0]   A = '0;
   logic [W-1:0]   B = '0;
   logic           loadA = 1'b0;
   logic           loadB = 1'b0;
   logic           ini_mult = 1'b0;
   logic [2*W-1:0] P;
   logic           fim_mult;
   logic           busy;

   int errors = 0;
   int checks = 0;

   em604_multiplicador #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .loadA    (loadA),
      .loadB    (loadB),
      .ini_mult (ini_mult),
      .P        (P),
      .fim_mult (fim_mult),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      bit             bypass;  // load operands on the start edge itself
      logic [2*W-1:0] exp_p;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Loads operands (beforehand or on the start edge) and issues the start edge.
   task automatic start_run(input logic [W-1:0] a, input logic [W-1:0] b, input bit bypass);
      if (!bypass) begin
         @(negedge clk);
         A = a; B = b; loadA = 1'b1; loadB = 1'b1;
         @(negedge clk);
         loadA = 1'b0; loadB = 1'b0; A = c_ga; B = c_gb;
      end
      @(negedge clk);
      if (bypass) begin
         A = a; B = b; loadA = 1'b1; loadB = 1'b1;
      end
      ini_mult = 1'b1;
      @(posedge clk); #1;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("fim_low_after_start", {31'd0, fim_mult}, 32'd0);
      @(negedge clk);
      ini_mult = 1'b0; loadA = 1'b0; loadB = 1'b0; A = c_ga; B = c_gb;
   endtask

   // Counts edges after the start edge until fim_mult. Optionally pulses
   // ini_mult plus garbage loads before edge pulse_at, or returns right
   // after edge stop_at so the caller can apply reset.
   task automatic run_wait(input int pulse_at, input int stop_at, output int n);
      n = 0;
      while (fim_mult !== 1'b1 && n < 40) begin
         if (n + 1 == pulse_at) begin
            ini_mult = 1'b1; loadA = 1'b1; loadB = 1'b1; A = 8'hFF; B = 8'hFF;
         end else begin
            ini_mult = 1'b0; loadA = 1'b0; loadB = 1'b0; A = c_ga; B = c_gb;
         end
         @(posedge clk); #1;
         n++;
         if (n == stop_at) begin
            ini_mult = 1'b0; loadA = 1'b0; loadB = 1'b0;
            return;
         end
      end
      ini_mult = 1'b0; loadA = 1'b0; loadB = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int pulse_at);
      int n;
      start_run(v.a, v.b, v.bypass);
      run_wait(pulse_at, -1, n);
      chk($sformatf("latency_%0d_x_%0d", v.a, v.b), n, LAT);
      chk($sformatf("product_%0d_x_%0d", v.a, v.b), {16'd0, P}, {16'd0, v.exp_p});
      chk($sformatf("busy_done_%0d_x_%0d", v.a, v.b), {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic [2*W-1:0] held;

      vecs[0] = '{a: 8'd13,  b: 8'd11,  bypass: 1'b0, exp_p: 16'h008F};
      vecs[1] = '{a: 8'd255, b: 8'd255, bypass: 1'b0, exp_p: 16'hFE01};
      vecs[2] = '{a: 8'd0,   b: 8'hA5,  bypass: 1'b0, exp_p: 16'h0000};
      vecs[3] = '{a: 8'd7,   b: 8'd9,   bypass: 1'b1, exp_p: 16'h003F};
      vecs[4] = '{a: 8'd1,   b: 8'd255, bypass: 1'b0, exp_p: 16'h00FF};
      vecs[5] = '{a: 8'd128, b: 8'd2,   bypass: 1'b1, exp_p: 16'h0100};
      vecs[6] = '{a: 8'd200, b: 8'd100, bypass: 1'b0, exp_p: 16'h4E20};
      vecs[7] = '{a: 8'd255, b: 8'd1,   bypass: 1'b1, exp_p: 16'h00FF};

      // Reset state
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_P", {16'd0, P}, 32'd0);
      chk("reset_fim", {31'd0, fim_mult}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Vector table; runs after the first restart from FIM
      foreach (vecs[i]) run_vec(vecs[i], -1);

      // Done state holds P and fim_mult while ini_mult stays low
      held = P;
      repeat (3) @(posedge clk);
      #1;
      chk("fim_held", {31'd0, fim_mult}, 32'd1);
      chk("P_held", {16'd0, P}, {16'd0, held});

      // ini_mult and loads pulsed at cycle 5 of a run are ignored
      run_vec(vecs[0], 5);

      // Reset at cycle 6 of a run aborts it
      start_run(8'd255, 8'd255, 1'b0);
      run_wait(-1, 6, n);
      chk("midrun_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrun_rst_P", {16'd0, P}, 32'd0);
      chk("midrun_rst_fim", {31'd0, fim_mult}, 32'd0);
      chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("midrun_rst_held_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      // Starting with only ini_mult (no loads) after reset: registers are zero
      @(negedge clk);
      ini_mult = 1'b1;
      @(posedge clk); #1;
      ini_mult = 1'b0;
      run_wait(-1, -1, n);
      chk("post_rst_zero_latency", n, LAT);
      chk("post_rst_zero_product", {16'd0, P}, 32'd0);

      // New run after reset gives the correct product
      run_vec(vecs[3], -1);
      run_vec('{a: 8'd7, b: 8'd9, bypass: 1'b0, exp_p: 16'h003F}, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
